// File: rtl/launch_pkg.sv
// Shared state, fault and timer definitions for the igniter launch sequencer.
package launch_pkg;

    localparam int TIMER_W = 29;

    typedef enum logic [2:0] {
        SAFE   = 3'd0,
        CHARGE = 3'd1,
        READY  = 3'd2,
        FIRE   = 3'd3,
        DUMP   = 3'd4,
        FAULT  = 3'd5
    } seq_state_t;

    typedef enum logic [1:0] {
        FAULT_NONE        = 2'd0,
        FAULT_CHG_TIMEOUT = 2'd1,
        FAULT_CONT_LOST   = 2'd2
    } fault_t;

endpackage

// File: rtl/launch_debounce.sv
// Two-flop synchronizer plus stable-sample debouncer with one-cycle rise/fall pulses.
module launch_debounce #(
    parameter int DEBOUNCE_CYCLES = 480000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] stable_cnt;

    // stable_cnt counts consecutive synchronized samples that disagree with level
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_p0    <= 1'b0;
            sync_p1    <= 1'b0;
            stable_cnt <= '0;
            level      <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            if (sync_p1 == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_cnt <= '0;
                level      <= sync_p1;
                rise       <= sync_p1;
                fall       <= ~sync_p1;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/launch_sequencer.sv
// SAFE/CHARGE/READY/FIRE/DUMP/FAULT sequencer driving the igniter HV charger, firing switch and dump.
module launch_sequencer
    import launch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 480000,
    parameter int CHARGE_TIMEOUT  = 480000000,
    parameter int PWM_PERIOD      = 1024,
    parameter int PWM_ON          = 64,
    parameter int FIRE_CYCLES     = 48000000,
    parameter int DUMP_CYCLES     = 4800000,
    parameter int BLINK_BIT       = 22
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       arm_button,
    input  logic       fire_button,
    input  logic       cont,
    input  logic       lt3420_done,
    output logic       lt3420_charge,
    output logic       pwm,
    output logic       dump,
    output logic       arm_led,
    output logic       cont_led,
    output logic [2:0] state,
    output logic [1:0] fault
);

    localparam int PWM_W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;

    logic arm_level, arm_rise, arm_fall;
    logic fire_level, fire_rise, fire_fall;
    logic cont_p0, cont_p1, done_p0, done_p1;
    logic unused_debounce;

    seq_state_t         state_q, state_d;
    fault_t             fault_q, fault_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic               dump_d, charge_d, pwm_d, arm_led_d;

    launch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_arm_debounce (
        .clk(clk), .reset_n(reset_n), .raw(arm_button),
        .level(arm_level), .rise(arm_rise), .fall(arm_fall)
    );

    launch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_fire_debounce (
        .clk(clk), .reset_n(reset_n), .raw(fire_button),
        .level(fire_level), .rise(fire_rise), .fall(fire_fall)
    );

    assign unused_debounce = &{1'b0, arm_fall, fire_level, fire_fall};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cont_p0 <= 1'b0;
            cont_p1 <= 1'b0;
            done_p0 <= 1'b0;
            done_p1 <= 1'b0;
        end else begin
            cont_p0 <= cont;
            cont_p1 <= cont_p0;
            done_p0 <= lt3420_done;
            done_p1 <= done_p0;
        end
    end

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        case (state_q)
            SAFE: if (arm_rise && cont_p1) begin
                state_d = CHARGE;
                fault_d = FAULT_NONE;
            end
            CHARGE: begin
                if (!arm_level) begin
                    state_d = DUMP;
                end else if (!cont_p1) begin
                    state_d = FAULT;
                    fault_d = FAULT_CONT_LOST;
                end else if (timer_q >= TIMER_W'(CHARGE_TIMEOUT - 1)) begin
                    state_d = FAULT;
                    fault_d = FAULT_CHG_TIMEOUT;
                end else if (done_p1) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (!arm_level) begin
                    state_d = DUMP;
                end else if (!cont_p1) begin
                    state_d = FAULT;
                    fault_d = FAULT_CONT_LOST;
                end else if (fire_rise) begin
                    state_d = FIRE;
                end
            end
            // Continuity and arm are deliberately ignored: the igniter opens as it burns.
            FIRE:  if (timer_q >= TIMER_W'(FIRE_CYCLES - 1)) state_d = DUMP;
            DUMP:  if (timer_q >= TIMER_W'(DUMP_CYCLES - 1)) state_d = SAFE;
            FAULT: if (!arm_level && timer_q >= TIMER_W'(DUMP_CYCLES - 1)) state_d = SAFE;
            default: state_d = SAFE;
        endcase

        timer_d = (state_d != state_q) ? '0 : ((&timer_q) ? timer_q : timer_q + 1'b1);

        pwm_cnt_d = '0;
        if (state_d == FIRE && state_q == FIRE)
            pwm_cnt_d = (pwm_cnt_q == PWM_W'(PWM_PERIOD - 1)) ? '0 : pwm_cnt_q + 1'b1;

        // Outputs decode from the next state so they change on the same edge as state.
        dump_d    = 1'b1;
        charge_d  = 1'b0;
        pwm_d     = 1'b0;
        arm_led_d = 1'b0;
        case (state_d)
            CHARGE: begin
                dump_d    = 1'b0;
                charge_d  = 1'b1;
                arm_led_d = timer_d[BLINK_BIT];
            end
            READY: begin
                dump_d    = 1'b0;
                charge_d  = 1'b1;
                arm_led_d = 1'b1;
            end
            FIRE: begin
                dump_d    = 1'b0;
                pwm_d     = (pwm_cnt_d < PWM_W'(PWM_ON));
                arm_led_d = 1'b1;
            end
            FAULT:   arm_led_d = timer_d[BLINK_BIT-2];
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= SAFE;
            fault_q       <= FAULT_NONE;
            timer_q       <= '0;
            pwm_cnt_q     <= '0;
            dump          <= 1'b1;
            lt3420_charge <= 1'b0;
            pwm           <= 1'b0;
            arm_led       <= 1'b0;
        end else begin
            state_q       <= state_d;
            fault_q       <= fault_d;
            timer_q       <= timer_d;
            pwm_cnt_q     <= pwm_cnt_d;
            dump          <= dump_d;
            lt3420_charge <= charge_d;
            pwm           <= pwm_d;
            arm_led       <= arm_led_d;
        end
    end

    assign state    = state_q;
    assign fault    = fault_q;
    assign cont_led = cont_p1;

endmodule

// File: tb/tb_launch_sequencer.sv
// Self-checking bench for launch_sequencer: scenario tasks plus a cycle reference model.
module tb_launch_sequencer;

    localparam int DEB = 4;
    localparam int PP  = 8;
    localparam int PON = 2;
    localparam int FC  = 32;
    localparam int CT  = 100;
    localparam int DC  = 16;
    localparam int BB  = 3;

    localparam int S_SAFE = 0, S_CHARGE = 1, S_READY = 2, S_FIRE = 3, S_DUMP = 4, S_FAULT = 5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       arm_button = 1'b0, fire_button = 1'b0, cont = 1'b0, lt3420_done = 1'b0;
    logic       lt3420_charge, pwm, dump, arm_led, cont_led;
    logic [2:0] state;
    logic [1:0] fault;

    int checks = 0, errors = 0, diff_cnt = 0, inv_bad = 0;
    logic [9:0] last_obs, last_exp;

    // Reference model: time-in-state counter, sample windows for debouncing.
    int   m_state, m_fault, m_time;
    logic m_arm_s1, m_arm_s2, m_fire_s1, m_fire_s2, m_cont_s1, m_cont_s2, m_done_s1, m_done_s2;
    logic m_arm_lvl, m_fire_lvl, m_arm_rise, m_fire_rise;
    logic [DEB-1:0] arm_win, fire_win;
    int   arm_n, fire_n;

    launch_sequencer #(
        .DEBOUNCE_CYCLES(DEB), .CHARGE_TIMEOUT(CT), .PWM_PERIOD(PP), .PWM_ON(PON),
        .FIRE_CYCLES(FC), .DUMP_CYCLES(DC), .BLINK_BIT(BB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .arm_button(arm_button), .fire_button(fire_button),
        .cont(cont), .lt3420_done(lt3420_done), .lt3420_charge(lt3420_charge), .pwm(pwm),
        .dump(dump), .arm_led(arm_led), .cont_led(cont_led), .state(state), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_state = S_SAFE; m_fault = 0; m_time = 0;
        m_arm_s1 = 0; m_arm_s2 = 0; m_fire_s1 = 0; m_fire_s2 = 0;
        m_cont_s1 = 0; m_cont_s2 = 0; m_done_s1 = 0; m_done_s2 = 0;
        m_arm_lvl = 0; m_fire_lvl = 0; m_arm_rise = 0; m_fire_rise = 0;
        arm_win = '0; fire_win = '0; arm_n = 0; fire_n = 0;
    endtask

    task automatic model_step();
        int ns, nf;
        if (!reset_n) begin
            model_clear();
            return;
        end
        ns = m_state; nf = m_fault;
        case (m_state)
            S_SAFE:   if (m_arm_rise && m_cont_s2) begin ns = S_CHARGE; nf = 0; end
            S_CHARGE: if (!m_arm_lvl) ns = S_DUMP;
                      else if (!m_cont_s2) begin ns = S_FAULT; nf = 2; end
                      else if (m_time + 1 >= CT) begin ns = S_FAULT; nf = 1; end
                      else if (m_done_s2) ns = S_READY;
            S_READY:  if (!m_arm_lvl) ns = S_DUMP;
                      else if (!m_cont_s2) begin ns = S_FAULT; nf = 2; end
                      else if (m_fire_rise) ns = S_FIRE;
            S_FIRE:   if (m_time + 1 >= FC) ns = S_DUMP;
            S_DUMP:   if (m_time + 1 >= DC) ns = S_SAFE;
            S_FAULT:  if (!m_arm_lvl && m_time + 1 >= DC) ns = S_SAFE;
            default:  ns = S_SAFE;
        endcase
        m_time  = (ns != m_state) ? 0 : m_time + 1;
        m_state = ns;
        m_fault = nf;

        arm_win = {arm_win[DEB-2:0], m_arm_s2};
        if (arm_n < DEB) arm_n++;
        m_arm_rise = 1'b0;
        if (arm_n == DEB && arm_win == {DEB{~m_arm_lvl}}) begin
            m_arm_lvl = ~m_arm_lvl;
            m_arm_rise = m_arm_lvl;
        end
        fire_win = {fire_win[DEB-2:0], m_fire_s2};
        if (fire_n < DEB) fire_n++;
        m_fire_rise = 1'b0;
        if (fire_n == DEB && fire_win == {DEB{~m_fire_lvl}}) begin
            m_fire_lvl = ~m_fire_lvl;
            m_fire_rise = m_fire_lvl;
        end

        m_arm_s2 = m_arm_s1;   m_arm_s1 = arm_button;
        m_fire_s2 = m_fire_s1; m_fire_s1 = fire_button;
        m_cont_s2 = m_cont_s1; m_cont_s1 = cont;
        m_done_s2 = m_done_s1; m_done_s1 = lt3420_done;
    endtask

    function automatic logic [9:0] obs_vec();
        return {state, fault, dump, lt3420_charge, pwm, arm_led, cont_led};
    endfunction

    function automatic logic [9:0] exp_vec();
        logic e_dump, e_chg, e_pwm, e_led;
        e_dump = (m_state == S_SAFE) || (m_state == S_DUMP) || (m_state == S_FAULT);
        e_chg  = (m_state == S_CHARGE) || (m_state == S_READY);
        e_pwm  = (m_state == S_FIRE) && ((m_time % PP) < PON);
        case (m_state)
            S_CHARGE:        e_led = ((m_time >> BB) & 1) != 0;
            S_READY, S_FIRE: e_led = 1'b1;
            S_FAULT:         e_led = ((m_time >> (BB - 2)) & 1) != 0;
            default:         e_led = 1'b0;
        endcase
        return {3'(m_state), 2'(m_fault), e_dump, e_chg, e_pwm, e_led, m_cont_s2};
    endfunction

    task automatic tick();
        logic [9:0] o, e;
        @(posedge clk);
        model_step();
        #1;
        o = obs_vec();
        e = exp_vec();
        if (o !== e) begin
            diff_cnt++;
            last_obs = o;
            last_exp = e;
        end
        if ((pwm && state != 3'(S_FIRE)) || (lt3420_charge && (pwm || dump))) inv_bad++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        arm_button = 0; fire_button = 0; cont = 0; lt3420_done = 0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_state(input int s, input int budget, output int n, output bit ok);
        n = 0; ok = 1'b1;
        while (int'(state) != s) begin
            if (n >= budget) begin ok = 1'b0; return; end
            tick();
            n++;
        end
    endtask

    task automatic count_in_state(input int s, input int budget, output int n);
        n = 0;
        while (int'(state) == s && n < budget) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        arm_button = 1; fire_button = 1; cont = 1; lt3420_done = 1;
        tick(); tick();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++; if (dump !== 1'b1) begin errors++; $display("FAIL reset_dump: got %b want 1", dump); end
        checks++; if ({lt3420_charge, pwm, arm_led, cont_led} !== 4'b0000)
            begin errors++; $display("FAIL reset_outs: chg/pwm/led/cont got %b want 0000", {lt3420_charge, pwm, arm_led, cont_led}); end
        checks++; if (fault !== 2'd0) begin errors++; $display("FAIL reset_fault: got %0d want 0", fault); end
        arm_button = 0; fire_button = 0; cont = 0; lt3420_done = 0;
        reset_n = 1'b1;
        repeat (3) tick();
        checks++; if (diff_cnt != 0) begin errors++; $display("FAIL reset_model: %0d cycles differ, dut=%b model=%b", diff_cnt, last_obs, last_exp); end
        diff_cnt = 0;
    endtask

    task automatic test_normal_cycle();
        int seq[$];
        int exp_seq[6] = '{0, 1, 2, 3, 4, 0};
        int n, cur, chg_cycles = 0, fire_hold = 0, pwm_high = 0, pulses = 0, fire_len = 0, dump_len = 0, not_safe = 0;
        bit ok, finished = 0, fire_pressed = 0;
        logic pwm_prev = 1'b0;
        do_reset();
        seq.push_back(int'(state));
        cont = 1; arm_button = 1;
        wait_state(S_CHARGE, 20, n, ok);
        checks++; if (!ok || n != 2 + DEB + 1) begin errors++; $display("FAIL normal_arm_latency: got %0d cycles want %0d", n, 2 + DEB + 1); end
        for (int c = 0; c < 400 && !finished; c++) begin
            cur = int'(state);
            if (cur != seq[$]) seq.push_back(cur);
            if (cur == S_CHARGE) begin chg_cycles++; if (chg_cycles == 20) lt3420_done = 1; end
            if (cur == S_READY && !fire_pressed) begin fire_button = 1; fire_pressed = 1; end
            if (fire_button) begin fire_hold++; if (fire_hold == 10) fire_button = 0; end
            if (pwm) pwm_high++;
            if (pwm && !pwm_prev) pulses++;
            pwm_prev = pwm;
            if (cur == S_FIRE) fire_len++;
            if (cur == S_DUMP) dump_len++;
            if (cur == S_SAFE && seq.size() > 1) finished = 1;
            else tick();
        end
        ok = (seq.size() == 6);
        for (int i = 0; i < seq.size() && i < 6; i++) if (seq[i] != exp_seq[i]) ok = 0;
        checks++; if (!ok) begin errors++; $display("FAIL normal_sequence: %0d states seen, last %0d, want 0,1,2,3,4,0", seq.size(), seq[$]); end
        checks++; if (pulses != FC / PP) begin errors++; $display("FAIL normal_pwm_pulses: got %0d want %0d", pulses, FC / PP); end
        checks++; if (pwm_high != (FC / PP) * PON) begin errors++; $display("FAIL normal_pwm_high: got %0d want %0d", pwm_high, (FC / PP) * PON); end
        checks++; if (fire_len != FC) begin errors++; $display("FAIL normal_fire_len: got %0d want %0d", fire_len, FC); end
        checks++; if (dump_len != DC) begin errors++; $display("FAIL normal_dump_len: got %0d want %0d", dump_len, DC); end
        repeat (12) begin tick(); if (state !== 3'(S_SAFE)) not_safe++; end
        checks++; if (not_safe != 0) begin errors++; $display("FAIL normal_held_arm_rearm: %0d cycles outside SAFE want 0", not_safe); end
        arm_button = 0; lt3420_done = 0;
        repeat (10) tick();
        checks++; if (diff_cnt != 0) begin errors++; $display("FAIL normal_model: %0d cycles differ, dut=%b model=%b", diff_cnt, last_obs, last_exp); end
        diff_cnt = 0;
    endtask

    task automatic test_bounce();
        int bad = 0;
        do_reset();
        cont = 1;
        for (int i = 0; i < 20; i++) begin
            arm_button = ((i / 2) % 2 == 0);
            tick();
            if (state !== 3'(S_SAFE) || dump !== 1'b1) bad++;
        end
        arm_button = 0;
        repeat (10) begin tick(); if (state !== 3'(S_SAFE) || dump !== 1'b1) bad++; end
        checks++; if (bad != 0) begin errors++; $display("FAIL bounce_safe: %0d bad cycles want 0", bad); end
        checks++; if (diff_cnt != 0) begin errors++; $display("FAIL bounce_model: %0d cycles differ, dut=%b model=%b", diff_cnt, last_obs, last_exp); end
        diff_cnt = 0;
    endtask

    task automatic test_charge_timeout();
        int n;
        bit ok;
        do_reset();
        cont = 1; lt3420_done = 0; arm_button = 1;
        wait_state(S_CHARGE, 20, n, ok);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_enter_charge: state %0d want 1", state); end
        count_in_state(S_CHARGE, 200, n);
        checks++; if (n != CT) begin errors++; $display("FAIL timeout_charge_len: got %0d want %0d", n, CT); end
        checks++; if (state !== 3'(S_FAULT) || fault !== 2'd1 || dump !== 1'b1)
            begin errors++; $display("FAIL timeout_fault: state %0d fault %0d dump %b want 5 1 1", state, fault, dump); end
        arm_button = 0;
        count_in_state(S_FAULT, 100, n);
        checks++; if (n != DC || state !== 3'(S_SAFE)) begin errors++; $display("FAIL timeout_fault_len: got %0d state %0d want %0d state 0", n, state, DC); end
        checks++; if (fault !== 2'd1) begin errors++; $display("FAIL timeout_fault_sticky: got %0d want 1", fault); end
        arm_button = 1;
        wait_state(S_CHARGE, 20, n, ok);
        checks++; if (!ok || fault !== 2'd0) begin errors++; $display("FAIL timeout_fault_clear: state %0d fault %0d want 1 0", state, fault); end
        arm_button = 0;
        wait_state(S_SAFE, 60, n, ok);
        checks++; if (diff_cnt != 0) begin errors++; $display("FAIL timeout_model: %0d cycles differ, dut=%b model=%b", diff_cnt, last_obs, last_exp); end
        diff_cnt = 0;
    endtask

    task automatic test_cont_loss();
        int n;
        bit ok;
        do_reset();
        cont = 1; lt3420_done = 1; arm_button = 1;
        wait_state(S_READY, 30, n, ok);
        repeat (3) tick();
        cont = 0;
        wait_state(S_FAULT, 10, n, ok);
        checks++; if (!ok || n != 3) begin errors++; $display("FAIL contloss_latency: got %0d want 3", n); end
        checks++; if (fault !== 2'd2 || dump !== 1'b1 || lt3420_charge !== 1'b0)
            begin errors++; $display("FAIL contloss_fault: fault %0d dump %b chg %b want 2 1 0", fault, dump, lt3420_charge); end
        arm_button = 0;
        wait_state(S_SAFE, 60, n, ok);
        cont = 1;
        repeat (3) tick();
        arm_button = 1;
        wait_state(S_READY, 30, n, ok);
        fire_button = 1;
        wait_state(S_FIRE, 20, n, ok);
        checks++; if (!ok) begin errors++; $display("FAIL contloss_enter_fire: state %0d want 3", state); end
        cont = 0; arm_button = 0;
        count_in_state(S_FIRE, 100, n);
        checks++; if (n != FC || state !== 3'(S_DUMP)) begin errors++; $display("FAIL contloss_fire_len: got %0d state %0d want %0d state 4", n, state, FC); end
        fire_button = 0;
        wait_state(S_SAFE, 40, n, ok);
        checks++; if (diff_cnt != 0) begin errors++; $display("FAIL contloss_model: %0d cycles differ, dut=%b model=%b", diff_cnt, last_obs, last_exp); end
        diff_cnt = 0;
    endtask

    task automatic test_fire_held();
        int n, not_ready = 0, pwm_seen = 0;
        bit ok;
        do_reset();
        cont = 1; lt3420_done = 0;
        arm_button = 1; fire_button = 1;
        wait_state(S_CHARGE, 20, n, ok);
        checks++; if (!ok) begin errors++; $display("FAIL held_arm_wins: state %0d want 1", state); end
        repeat (5) begin tick(); if (pwm) pwm_seen++; end
        lt3420_done = 1;
        wait_state(S_READY, 20, n, ok);
        repeat (20) begin tick(); if (state !== 3'(S_READY)) not_ready++; if (pwm) pwm_seen++; end
        checks++; if (not_ready != 0) begin errors++; $display("FAIL held_fire_stays_ready: %0d cycles left READY want 0", not_ready); end
        arm_button = 0;
        wait_state(S_DUMP, 20, n, ok);
        checks++; if (!ok) begin errors++; $display("FAIL held_release_dump: state %0d want 4", state); end
        while (state == 3'(S_DUMP) && n < 60) begin tick(); n++; if (pwm) pwm_seen++; end
        checks++; if (pwm_seen != 0) begin errors++; $display("FAIL held_no_pwm: %0d pwm cycles want 0", pwm_seen); end
        fire_button = 0; lt3420_done = 0;
        repeat (10) tick();
        checks++; if (diff_cnt != 0) begin errors++; $display("FAIL held_model: %0d cycles differ, dut=%b model=%b", diff_cnt, last_obs, last_exp); end
        diff_cnt = 0;
    endtask

    task automatic test_reset_in_fire();
        int n;
        bit ok;
        do_reset();
        cont = 1; lt3420_done = 1; arm_button = 1;
        wait_state(S_READY, 30, n, ok);
        fire_button = 1;
        wait_state(S_FIRE, 20, n, ok);
        checks++; if (!ok || pwm !== 1'b1) begin errors++; $display("FAIL rstfire_first_pwm: state %0d pwm %b want 3 1", state, pwm); end
        repeat (PP) tick();
        checks++; if (state !== 3'(S_FIRE) || pwm !== 1'b1) begin errors++; $display("FAIL rstfire_pwm_period: state %0d pwm %b want 3 1", state, pwm); end
        reset_n = 1'b0;
        tick();
        checks++; if (pwm !== 1'b0 || dump !== 1'b1 || state !== 3'(S_SAFE) || fault !== 2'd0)
            begin errors++; $display("FAIL rstfire_outputs: pwm %b dump %b state %0d fault %0d want 0 1 0 0", pwm, dump, state, fault); end
        reset_n = 1'b1;
        arm_button = 0; fire_button = 0; lt3420_done = 0;
        repeat (10) tick();
        checks++; if (diff_cnt != 0) begin errors++; $display("FAIL rstfire_model: %0d cycles differ, dut=%b model=%b", diff_cnt, last_obs, last_exp); end
        diff_cnt = 0;
    endtask

    task automatic test_random();
        do_reset();
        cont = 1;
        inv_bad = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 29) == 0) arm_button = ~arm_button;
            if ($urandom_range(0, 19) == 0) fire_button = ~fire_button;
            if ($urandom_range(0, 149) == 0) cont = ~cont;
            if ($urandom_range(0, 24) == 0) lt3420_done = ~lt3420_done;
            reset_n = ($urandom_range(0, 999) != 0);
            tick();
        end
        reset_n = 1'b1;
        tick();
        checks++; if (diff_cnt != 0) begin errors++; $display("FAIL random_model: %0d cycles differ, dut=%b model=%b", diff_cnt, last_obs, last_exp); end
        checks++; if (inv_bad != 0) begin errors++; $display("FAIL random_interlock: %0d bad cycles want 0", inv_bad); end
        diff_cnt = 0;
    endtask

    initial begin
        model_clear();
        last_obs = '0;
        last_exp = '0;
        test_reset();
        test_normal_cycle();
        test_bounce();
        test_charge_timeout();
        test_cont_loss();
        test_fire_held();
        test_reset_in_fire();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
